// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding, button
// indices and default timing for a 25 MHz system clock.
package button_conditioner_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;

    localparam int DEF_N_BTN           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 250_000;     // 10 ms at 25 MHz
    localparam int DEF_REPEAT_DELAY    = 12_500_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 2_500_000;   // 100 ms

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ARM  = ST_ARM,
        HELD = ST_HELD,
        REL  = ST_REL
    } btn_state_e;

    // Counter width able to hold max_count-1, never narrower than one bit.
    function automatic int counter_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioned button: 2-flop synchroniser, debounce FSM with a
// stable-cycle counter, and an auto-repeat timer that pauses during release glitches.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pressed_async,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = counter_width(DEBOUNCE_CYCLES);
    localparam int RPT_W   = counter_width(RPT_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [RPT_W-1:0] rpt_tmr;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the two sync stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= pressed_async;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rpt_tmr       <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (sync_q) begin
                        state <= ST_ARM;
                        cnt   <= '0;
                    end
                end

                ST_ARM: begin
                    if (!sync_q) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state        <= ST_HELD;
                        level        <= 1'b1;
                        press_pulse  <= 1'b1;
                        repeat_pulse <= 1'b1;
                        rpt_tmr      <= RPT_FIRST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_HELD: begin
                    if (!sync_q) begin
                        state <= ST_REL;
                        cnt   <= '0;
                    end else if (REPEAT_EN) begin
                        if (rpt_tmr == '0) begin
                            repeat_pulse <= 1'b1;
                            rpt_tmr      <= RPT_NEXT;
                        end else begin
                            rpt_tmr <= rpt_tmr - 1'b1;
                        end
                    end
                end

                ST_REL: begin
                    // Returning to HELD leaves rpt_tmr untouched so the schedule resumes.
                    if (sync_q) begin
                        state <= ST_HELD;
                    end else if (cnt == CNT_LAST) begin
                        state         <= ST_IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board push-buttons {down, up, right, left} into clean levels,
// press/release pulses and auto-repeat pulses for the physics block.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    logic [N_BTN-1:0] btn_pressed;

    // After this XOR a 1 always means pressed, whatever the board wiring.
    assign btn_pressed = btn_raw ^ {N_BTN{ACTIVE_LOW}};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_EN)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .pressed_async(btn_pressed[i]),
            .level        (btn_level[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i]),
            .repeat_pulse (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed scenarios plus random button activity, all
// compared against a run-length / tick-count model of the conditioner.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .N_BTN(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: two-stage delay of the pressed value, then the level flips once
    // the delayed value has disagreed with it for D+1 consecutive samples.
    // Repeats fire at held-tick counts RD, RD+RP, RD+2RP, ...
    bit m_s1 [4];
    bit m_s  [4];
    bit m_lvl[4];
    int m_run[4];
    int m_ticks[4];
    logic [3:0] e_lvl, e_press, e_rel, e_rpt;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 1'b0; m_s[i] = 1'b0; m_lvl[i] = 1'b0;
            m_run[i] = 0;   m_ticks[i] = 0;
        end
        e_lvl = '0; e_press = '0; e_rel = '0; e_rpt = '0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        for (int i = 0; i < 4; i++) begin
            bit x;
            x = m_s[i];
            m_s[i]  = m_s1[i];
            m_s1[i] = ~raw[i];
            e_press[i] = 1'b0; e_rel[i] = 1'b0; e_rpt[i] = 1'b0;
            if (m_lvl[i] && x && m_run[i] == 0) begin
                m_ticks[i]++;
                if (m_ticks[i] >= RD && (m_ticks[i] - RD) % RP == 0) e_rpt[i] = 1'b1;
            end
            if (x != m_lvl[i]) m_run[i]++;
            else               m_run[i] = 0;
            if (m_run[i] == D + 1) begin
                m_run[i] = 0;
                m_lvl[i] = ~m_lvl[i];
                if (m_lvl[i]) begin
                    e_press[i] = 1'b1; e_rpt[i] = 1'b1; m_ticks[i] = 0;
                end else begin
                    e_rel[i] = 1'b1;
                end
            end
            e_lvl[i] = m_lvl[i];
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive raw at a falling edge, clock once, then compare on the next falling edge.
    task automatic step(input logic [3:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        @(negedge clk);
        check4("level",   btn_level,   e_lvl);
        check4("press",   btn_press,   e_press);
        check4("release", btn_release, e_rel);
        check4("repeat",  btn_repeat,  e_rpt);
    endtask

    task automatic check_all_zero(input string tag);
        check4(tag, btn_level | btn_press | btn_release | btn_repeat, 4'b0000);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        model_reset();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_all_zero("reset_hold");
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b1111);
    endtask

    initial begin
        logic [63:0] mask, exp_mask;
        int          n_press, n_rel;
        logic [3:0]  raw;

        rst_n   = 1'b0;
        btn_raw = 4'b1111;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        idle(4);

        // Clean press on left
        for (int e = 0; e < 20; e++) begin
            step(4'b1110);
            if (e == 5) check4("clean_level_pre", btn_level, 4'b0000);
            if (e == 6) begin
                check4("clean_press",  btn_press,  4'b0001);
                check4("clean_repeat", btn_repeat, 4'b0001);
                check4("clean_level",  btn_level,  4'b0001);
            end
            if (e == 7) check4("clean_press_one_cycle", btn_press, 4'b0000);
        end
        idle(12);

        // Bounce on right: 3 pressed, 1 released, 3 pressed, released
        for (int e = 0; e < 15; e++) begin
            raw = (e < 3 || (e >= 4 && e < 7)) ? 4'b1101 : 4'b1111;
            step(raw);
            check4("bounce_quiet", {1'b0, btn_level[1], btn_press[1], btn_release[1]}, 4'b0000);
        end
        idle(4);

        // Auto-repeat on up: held 40 cycles
        mask = '0; n_press = 0;
        for (int e = 0; e < 40; e++) begin
            step(4'b1011);
            mask[e] = btn_repeat[2];
            n_press += int'(btn_press[2]);
        end
        exp_mask = '0;
        exp_mask[6] = 1'b1; exp_mask[16] = 1'b1; exp_mask[21] = 1'b1;
        exp_mask[26] = 1'b1; exp_mask[31] = 1'b1; exp_mask[36] = 1'b1;
        check64("repeat_schedule", mask, exp_mask);
        check64("repeat_single_press", 64'(n_press), 64'd1);
        for (int e = 40; e < 52; e++) begin
            step(4'b1111);
            if (e == 45) check4("repeat_rel_pre", btn_release, 4'b0000);
            if (e == 46) check4("repeat_release", btn_release, 4'b0100);
        end

        // Release glitch on left: 2 released cycles mid-hold
        mask = '0; n_rel = 0;
        for (int e = 0; e < 45; e++) begin
            raw = (e == 20 || e == 21) ? 4'b1111 : 4'b1110;
            step(raw);
            mask[e] = btn_repeat[0];
            n_rel += int'(btn_release[0]);
            if (e >= 6) check4("glitch_level", {3'b000, btn_level[0]}, 4'b0001);
        end
        exp_mask = '0;
        exp_mask[6] = 1'b1; exp_mask[16] = 1'b1; exp_mask[21] = 1'b1;
        exp_mask[29] = 1'b1; exp_mask[34] = 1'b1; exp_mask[39] = 1'b1; exp_mask[44] = 1'b1;
        check64("glitch_schedule", mask, exp_mask);
        check64("glitch_no_release", 64'(n_rel), 64'd0);
        idle(12);

        // Reset while down is held
        for (int e = 0; e < 10; e++) step(4'b0111);
        check4("pre_reset_level", btn_level, 4'b1000);
        do_reset(3);
        n_rel = 0;
        for (int e = 0; e < 15; e++) begin
            step(4'b0111);
            n_rel += int'(btn_release[3]);
            if (e == 5) check4("post_reset_level_pre", btn_level, 4'b0000);
            if (e == 6) check4("post_reset_press", btn_press, 4'b1000);
        end
        check64("post_reset_no_release", 64'(n_rel), 64'd0);
        idle(12);

        // All four on the same edge
        for (int e = 0; e < 10; e++) begin
            step(4'b0000);
            if (e == 6) begin
                check4("all_press", btn_press, 4'b1111);
                check4("all_level", btn_level, 4'b1111);
            end
        end
        idle(12);

        // Random activity with occasional resets
        raw = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
            if ($urandom_range(0, 599) == 0) do_reset(int'($urandom_range(1, 4)));
            step(raw);
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Sits between the raw board push-buttons (left/right/up/down) and the physics simulator.
- Per button: 2-flop synchroniser, debounce state machine with a stable-cycle counter, and an auto-repeat timer.
- Produces a clean level, one-cycle press/release pulses, and a repeat pulse train, so the physics block never sees metastable or bouncing inputs.
- All buttons are independent; their timing is identical.

Parameters:
- N_BTN, 4, number of buttons; bit order {down, up, right, left}.
- ACTIVE_LOW, 1, raw input polarity; 1 means a pressed button reads 0.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles needed to accept a change (10 ms at 25 MHz); must be >= 2.
- REPEAT_DELAY, 12500000, cycles from the press pulse to the first auto-repeat pulse.
- REPEAT_PERIOD, 2500000, cycles between later auto-repeat pulses.
- REPEAT_EN, 1, 0 disables auto-repeat; btn_repeat then equals btn_press.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  N_BTN  unsynchronised button pins.
- btn_level  out  N_BTN  debounced level, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse on an accepted press.
- btn_release  out  N_BTN  one-cycle pulse on an accepted release.
- btn_repeat  out  N_BTN  one-cycle pulse on press, then after REPEAT_DELAY, then every REPEAT_PERIOD while held.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - Synchroniser flops load the not-pressed value.
  - FSMs go to IDLE and all counters clear.
- Normalisation: p = btn_raw XOR ACTIVE_LOW, then two flops give s.
- FSM per button, with counter cnt (width $clog2(DEBOUNCE_CYCLES)):
  - IDLE: s=1 -> ARM, cnt=0.
  - ARM: s=0 -> IDLE (bounce rejected, no pulse). Else if cnt==DEBOUNCE_CYCLES-1 -> HELD: press=1, repeat=1, rpt timer loaded with REPEAT_DELAY-1. Else cnt++.
  - HELD: s=0 -> REL, cnt=0. Else the rpt timer decrements; at 0, repeat=1 and the timer reloads with REPEAT_PERIOD-1.
  - REL: s=1 -> HELD with no pulse; the rpt timer holds its value (paused, not reset). Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE with release=1. Else cnt++.
- btn_level is 1 in HELD and REL, 0 in IDLE and ARM. It is registered and changes in the same cycle as the press/release pulse.
- Latency: if raw first reads pressed at edge k and stays stable, btn_press and btn_level are high after edge k+DEBOUNCE_CYCLES+2. Release is symmetric.
- Pulses are exactly one cycle and never occur while in reset.
- Simultaneous buttons are handled independently. Opposite directions held together both report; there is no arbitration here.
- The rpt timer and cnt saturate and never wrap; the logic is state-gated so wrap cannot occur.
- Reset mid-operation:
  - Any in-flight pulse is lost.
  - A button held through reset deassertion produces a fresh press DEBOUNCE_CYCLES+2 cycles after the first post-reset edge.
  - No release pulse is emitted for a button that was held before reset.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, ARM, HELD, REL}.
  - Button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3.
  - Default timing constants.
- Sub-module button_channel:
  - Contains one synchroniser, the FSM, and the two counters.
  - Instantiated N_BTN times by generate; the top only normalises polarity and concatenates outputs.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, ACTIVE_LOW=1):
- Clean press: btn_raw[0] driven 1->0 at edge 0 and held 20 cycles -> btn_press[0] and btn_repeat[0] high for exactly one cycle after edge 6; btn_level[0]=1 from edge 6; other bits stay 0.
- Bounce reject: btn_raw[1] pressed for 3 cycles, released for 1, pressed for 3, then released -> no press, release, or level activity on bit 1.
- Auto-repeat: hold btn_raw[2] for 40 cycles -> btn_repeat[2] pulses after edges 6, 16, 21, 26, 31, 36; a single btn_press; after release, btn_release[2] pulses 6 cycles after the raw edge.
- Release glitch: while held, raw goes released for 2 cycles, then pressed again -> no release pulse, level stays 1, and the repeat schedule resumes shifted by the paused cycles.
- Reset mid-hold: btn_raw[3] held, rst_n pulsed low for 3 cycles while pressed -> all outputs 0 immediately; a new press pulse arrives 6 cycles after rst_n rises; no release pulse.
- All four buttons pressed on the same edge -> all four press bits pulse in the same cycle; btn_level reads 4'b1111.
